// File: rtl/message_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : message_writer_if
//  Description : Byte-stream and memory-write bundle between a message source,
//                the message_writer and the message reader.
//  Revision    : 1.0  initial release
// ============================================================================
interface message_writer_if #(
    parameter int AW = 7
);
    logic          msg_valid;
    logic [7:0]    msg_byte;
    logic          msg_last;
    logic          msg_ready;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [7:0]    write_data;
    logic [AW-1:0] msg_length;
    logic          load_done;
    logic          overflow;
    logic          read_complete;

    // Writer side
    modport slave (
        input  msg_valid,
        input  msg_byte,
        input  msg_last,
        input  read_complete,
        output msg_ready,
        output write_enable,
        output write_address,
        output write_data,
        output msg_length,
        output load_done,
        output overflow
    );

    // Source / memory / reader side
    modport master (
        output msg_valid,
        output msg_byte,
        output msg_last,
        output read_complete,
        input  msg_ready,
        input  write_enable,
        input  write_address,
        input  write_data,
        input  msg_length,
        input  load_done,
        input  overflow
    );
endinterface
`default_nettype wire

// File: rtl/message_writer.sv
`default_nettype none
// ============================================================================
//  Module      : message_writer
//  Description : Loads a byte stream into message memory from address 0,
//                reports its length and holds it until the reader is done.
//  Revision    : 1.0  initial release
// ============================================================================
module message_writer #(
    parameter int MAX_MESSAGE_LENGTH = 55,
    parameter int AW                 = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
    input  wire logic        clock,
    input  wire logic        reset,
    message_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] c_max_count = AW'(MAX_MESSAGE_LENGTH);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_count;
    logic [AW-1:0] w_count_next;
    logic [AW-1:0] w_count_inc;
    logic          r_overflow;
    logic          w_overflow_next;
    logic          r_msg_ready;
    logic          r_write_enable;
    logic [AW-1:0] r_write_address;
    logic [7:0]    r_write_data;
    logic          r_load_done;
    logic          w_accept;

    assign w_accept    = bus.msg_valid & r_msg_ready;
    assign w_count_inc = r_count + AW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_overflow_next = r_overflow;
        case (r_state)
            IDLE, LOAD: begin
                if (w_accept) begin
                    w_count_next = w_count_inc;
                    if (bus.msg_last) begin
                        w_state_next = DONE;
                    end else if (w_count_inc == c_max_count) begin
                        // Buffer full without a last byte: truncate the message
                        w_state_next    = DONE;
                        w_overflow_next = 1'b1;
                    end else begin
                        w_state_next = LOAD;
                    end
                end
            end
            DONE: begin
                if (bus.read_complete) begin
                    w_state_next    = IDLE;
                    w_count_next    = '0;
                    w_overflow_next = 1'b0;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_count_next    = '0;
                w_overflow_next = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so ready/done track the state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count         <= '0;
            r_overflow      <= 1'b0;
            r_msg_ready     <= 1'b0;
            r_load_done     <= 1'b0;
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
        end else begin
            r_count        <= w_count_next;
            r_overflow     <= w_overflow_next;
            r_msg_ready    <= (w_state_next != DONE);
            r_load_done    <= (w_state_next == DONE);
            r_write_enable <= w_accept;
            if (w_accept) begin
                r_write_address <= r_count;
                r_write_data    <= bus.msg_byte;
            end
        end
    end

    assign bus.msg_ready     = r_msg_ready;
    assign bus.write_enable  = r_write_enable;
    assign bus.write_address = r_write_address;
    assign bus.write_data    = r_write_data;
    assign bus.msg_length    = r_count;
    assign bus.load_done     = r_load_done;
    assign bus.overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_message_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_message_writer
//  Description : Directed plus randomized self-checking bench for message_writer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_message_writer;

    localparam int c_max = 55;
    localparam int c_aw  = 7;

    logic clock = 1'b0;
    logic reset = 1'b0;

    message_writer_if #(.AW(c_aw)) bus ();

    message_writer #(
        .MAX_MESSAGE_LENGTH (c_max),
        .AW                 (c_aw)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: what the writer should present after each edge
    int         m_count;
    bit         m_done;
    bit         m_ovf;
    bit         m_ready;
    bit         m_we;
    int         m_wa;
    logic [7:0] m_wd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_done = 0; m_ovf = 0; m_ready = 0; m_we = 0; m_wa = 0; m_wd = '0;
    endtask

    task automatic check_outputs();
        chk("msg_ready", 32'(bus.msg_ready), 32'(m_ready));
        chk("write_enable", 32'(bus.write_enable), 32'(m_we));
        if (m_we) begin
            chk("write_address", 32'(bus.write_address), 32'(m_wa));
            chk("write_data", 32'(bus.write_data), 32'(m_wd));
        end
        chk("msg_length", 32'(bus.msg_length), 32'(m_count));
        chk("load_done", 32'(bus.load_done), 32'(m_done));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic check_reset_values();
        chk("rst_msg_ready", 32'(bus.msg_ready), 0);
        chk("rst_write_enable", 32'(bus.write_enable), 0);
        chk("rst_write_address", 32'(bus.write_address), 0);
        chk("rst_write_data", 32'(bus.write_data), 0);
        chk("rst_msg_length", 32'(bus.msg_length), 0);
        chk("rst_load_done", 32'(bus.load_done), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
    endtask

    // One clock: drive inputs, apply the message rules at the edge, then compare
    task automatic step(input bit v, input logic [7:0] b, input bit l, input bit rc, output bit acc);
        bus.msg_valid     = v;
        bus.msg_byte      = b;
        bus.msg_last      = l;
        bus.read_complete = rc;
        @(posedge clock);
        acc  = v && m_ready;
        m_we = acc;
        if (acc) begin
            m_wa = m_count;
            m_wd = b;
            m_count++;
            if (l) m_done = 1;
            else if (m_count == c_max) begin
                m_done = 1;
                m_ovf  = 1;
            end
        end else if (m_done && rc) begin
            m_done = 0; m_count = 0; m_ovf = 0;
        end
        m_ready = !m_done;
        #1;
        check_outputs();
    endtask

    task automatic idle_step(input bit rc);
        bit acc;
        step(1'b0, 8'h00, 1'b0, rc, acc);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit l);
        bit acc;
        int tries = 0;
        do begin
            step(1'b1, b, l, 1'b0, acc);
            tries++;
        end while (!acc && tries < 10);
        chk("byte_accepted_in_time", 32'(acc), 1);
    endtask

    // Random gaps, random bytes; read_complete noise in gaps must be ignored
    task automatic send_msg(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            if (m_done) break;
            repeat ($urandom_range(0, 2)) idle_step(1'($urandom_range(0, 1)));
            send_byte(8'($urandom), with_last && (i == n - 1));
        end
        idle_step(1'b0);
    endtask

    task automatic release_msg();
        bit acc;
        repeat ($urandom_range(0, 3)) step(1'b1, 8'($urandom), 1'b0, 1'b0, acc);
        step(1'b1, 8'hEE, 1'b0, 1'b1, acc);
        idle_step(1'b0);
    endtask

    initial begin
        bit acc;
        bus.msg_valid = 0; bus.msg_byte = '0; bus.msg_last = 0; bus.read_complete = 0;
        model_reset();
        #2;
        check_reset_values();
        @(negedge clock);
        reset = 1'b1;

        // Three-byte message back to back
        idle_step(1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        chk("abc_length", 32'(bus.msg_length), 3);
        chk("abc_load_done", 32'(bus.load_done), 1);
        chk("abc_ready_low", 32'(bus.msg_ready), 0);

        // Held byte in DONE is ignored until read_complete
        repeat (5) step(1'b1, 8'h44, 1'b1, 1'b0, acc);
        step(1'b1, 8'h44, 1'b1, 1'b1, acc);
        chk("rearm_load_done", 32'(bus.load_done), 0);
        chk("rearm_length", 32'(bus.msg_length), 0);
        chk("rearm_ready", 32'(bus.msg_ready), 1);
        step(1'b1, 8'h44, 1'b1, 1'b0, acc);
        idle_step(1'b1);
        chk("held_byte_addr", 32'(bus.write_address), 0);
        chk("held_byte_data", 32'(bus.write_data), 32'h44);
        idle_step(1'b0);

        // Four bytes with two-cycle gaps
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hA0 + 8'(i), i == 3);
            if (i < 3) repeat (2) idle_step(1'b0);
        end
        idle_step(1'b0);
        chk("gap_length", 32'(bus.msg_length), 4);
        release_msg();

        // Exact fit and overflow
        send_msg(c_max, 1'b1);
        chk("fit_length", 32'(bus.msg_length), c_max);
        chk("fit_overflow", 32'(bus.overflow), 0);
        release_msg();
        send_msg(60, 1'b0);
        chk("ovf_length", 32'(bus.msg_length), c_max);
        chk("ovf_overflow", 32'(bus.overflow), 1);
        chk("ovf_ready", 32'(bus.msg_ready), 0);
        release_msg();

        // Single-byte message
        send_byte(8'h80, 1'b1);
        chk("single_done", 32'(bus.load_done), 1);
        idle_step(1'b0);
        chk("single_addr", 32'(bus.write_address), 0);
        release_msg();

        // Reset in the middle of a message
        send_byte(8'h11, 1'b0);
        send_byte(8'h12, 1'b0);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        @(negedge clock);
        reset = 1'b1;
        idle_step(1'b0);
        send_byte(8'h5A, 1'b1);
        idle_step(1'b0);
        chk("post_reset_addr", 32'(bus.write_address), 0);
        chk("post_reset_length", 32'(bus.msg_length), 1);
        release_msg();

        // Randomized messages
        for (int k = 0; k < 10; k++) begin
            int n;
            n = $urandom_range(1, 62);
            send_msg(n, n <= c_max);
            release_msg();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
